cache_read_arbiter: RTL and testbench

Arbitrates the read-miss refill requests of the instruction cache and the data cache onto one AXI3 read-address/read-data channel pair. It sits directly downstream of both caches' arbitrater ports and upstream of the CPU's AXI master interface. It carries one outstanding burst at a time, routes the returned beats to the owning cache, and tags each burst with an AXI ID.

---
 rtl/cache_read_arbiter.sv | 148 ++++++++++++++
 tb/tb_cache_read_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_read_arbiter.sv
// Arbitrates icache/dcache refill bursts onto one AXI3 AR/R channel pair, one burst in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the dcache wins ties.
module cache_read_arbiter #(
  parameter logic [3:0] ID_I = 4'd0,
  parameter logic [3:0] ID_D = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   owner_rready;
`ifdef ARB_ROUND_ROBIN_EN
  logic   last_owner_q, last_owner_d;
`endif

  // Single burst in flight, so the response ID and status carry no routing information.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp};

  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign owner_rready = owner_q ? d_rready : i_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_arvalid || d_arvalid) begin
          state_d = S_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          owner_d = (i_arvalid && d_arvalid) ? ~last_owner_q : d_arvalid;
`else
          owner_d = d_arvalid;
`endif
        end
      end
      S_ADDR: begin
        if (arready) begin
          state_d = S_DATA;
`ifdef ARB_ROUND_ROBIN_EN
          last_owner_d = owner_q;
`endif
        end
      end
      S_DATA: begin
        if (rvalid && owner_rready && rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid   = 1'b0;
    arid      = '0;
    araddr    = '0;
    arlen     = '0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    rready    = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    d_rlast   = 1'b0;
    i_rdata   = rdata;
    d_rdata   = rdata;
    case (state_q)
      S_ADDR: begin
        arvalid = 1'b1;
        if (owner_q) begin
          arid      = ID_D;
          araddr    = d_araddr;
          arlen     = d_arlen;
          d_arready = arready;
        end else begin
          arid      = ID_I;
          araddr    = i_araddr;
          arlen     = i_arlen;
          i_arready = arready;
        end
      end
      S_DATA: begin
        rready = owner_rready;
        if (owner_q) begin
          d_rvalid = rvalid;
          d_rlast  = rlast;
        end else begin
          i_rvalid = rvalid;
          i_rlast  = rlast;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_read_arbiter.sv
// Randomized bench for cache_read_arbiter: cache and AXI-slave behaviour modelled here,
// expected grants from the arbitration rule, expected beats from the slave's own data.
module tb_cache_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata, araddr, rdata;
  logic [7:0]  i_arlen, d_arlen, arlen;
  logic        i_arvalid, d_arvalid, i_arready, d_arready;
  logic        i_rlast, d_rlast, i_rvalid, d_rvalid, i_rready, d_rready;
  logic [3:0]  arid, rid;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  bit          last_own;

  cache_read_arbiter #(.ID_I(4'd0), .ID_D(4'd1)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc > 50000) begin
      $display("FAIL timeout: cycles %0d limit 50000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  // Arbitration rule: lone requester wins; ties go to dcache or alternate with round-robin.
  function automatic bit pick(input bit iv, input bit dv, input bit last);
`ifdef ARB_ROUND_ROBIN_EN
    if (iv && dv) return !last;
`endif
    return dv;
  endfunction

  task automatic raise(input bit c);
    if (c) begin
      d_araddr = $urandom & 32'hFFFF_FFFC; d_arlen = 8'($urandom_range(7)); d_arvalid = 1'b1;
    end else begin
      i_araddr = $urandom & 32'hFFFF_FFFC; i_arlen = 8'($urandom_range(7)); i_arvalid = 1'b1;
    end
  endtask

  task automatic maybe_raise(input bit c);
    if ($urandom_range(9) == 0) begin
      if (c && !d_arvalid) raise(1'b1);
      if (!c && !i_arvalid) raise(1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
    i_arvalid = 1'b0; d_arvalid = 1'b0; i_araddr = '0; d_araddr = '0; i_arlen = '0; d_arlen = '0;
    i_rready = 1'b1; d_rready = 1'b1;
    tick(); tick();
    #1;
    chk("rst_arvalid", arvalid, 0); chk("rst_rready", rready, 0);
    chk("rst_arready", {i_arready, d_arready}, 0); chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    chk("rst_rlast", {i_rlast, d_rlast}, 0); chk("rst_arid", arid, 0);
    chk("rst_araddr", araddr, 0); chk("rst_arlen", arlen, 0);
    rst = 1'b0;
    last_own = 1'b1;
  endtask

  // Called one cycle after the grant decision edge; ends in the IDLE gap cycle (or after abort).
  task automatic serve_burst(input bit own, input int ar_stall, input int rv_pct, input int rr_pct,
                             input int rr_beat, input int abort_beat, input bit rnd, input bit fixed);
    logic [31:0] ea;
    logic [7:0]  el;
    int          b, hold;
    bit          pres, r;
    ea = own ? d_araddr : i_araddr;
    el = own ? d_arlen : i_arlen;
    for (int s = 0; s <= ar_stall; s++) begin
      arready = (s == ar_stall);
      if (rnd) maybe_raise(!own);
      #1;
      chk("arvalid", arvalid, 1); chk("araddr", araddr, ea); chk("arlen", arlen, el);
      chk("arid", arid, own ? 32'd1 : 32'd0); chk("arsize", arsize, 3'b010);
      chk("arburst", arburst, 2'b01); chk("rready_addr", rready, 0);
      chk("own_arready", own ? d_arready : i_arready, arready);
      chk("oth_arready", own ? i_arready : d_arready, 0);
      chk("rvalid_addr", {i_rvalid, d_rvalid}, 0);
      tick();
    end
    last_own = own;
    arready = 1'b0;
    if (own) d_arvalid = 1'b0; else i_arvalid = 1'b0;
    b = 0; hold = 0; pres = 1'b0;
    while (b <= int'(el)) begin
      if (rnd) maybe_raise(!own);
      if (!pres) begin
        if (int'($urandom_range(99)) < rv_pct) begin
          rvalid = 1'b0; rlast = 1'b0;
        end else begin
          rvalid = 1'b1; rlast = (b == int'(el)); pres = 1'b1;
          rdata = fixed ? 32'(32'h11 * (b + 1)) : $urandom;
        end
      end
      if (pres && b == abort_beat) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_arvalid", arvalid, 0); chk("abort_rready", rready, 0);
        chk("abort_i_rvalid", i_rvalid, 0); chk("abort_d_rvalid", d_rvalid, 0);
        rvalid = 1'b0; rlast = 1'b0; last_own = 1'b1;
        return;
      end
      r = !(int'($urandom_range(99)) < rr_pct);
      if (pres && b == rr_beat && hold < 3) begin r = 1'b0; hold++; end
      if (own) d_rready = r; else i_rready = r;
      #1;
      chk("rready", rready, r);
      chk("own_rvalid", own ? d_rvalid : i_rvalid, rvalid);
      chk("oth_rvalid", own ? i_rvalid : d_rvalid, 0);
      if (rvalid) begin
        chk("own_rdata", own ? d_rdata : i_rdata, rdata);
        chk("own_rlast", own ? d_rlast : i_rlast, rlast);
      end
      tick();
      if (pres && r) begin b++; pres = 1'b0; end
    end
    rvalid = 1'b0; rlast = 1'b0; i_rready = 1'b1; d_rready = 1'b1;
    #1;
    chk("gap_arvalid", arvalid, 0); chk("gap_rready", rready, 0);
  endtask

  task automatic next_burst(input int ar_stall, input int rv_pct, input int rr_pct,
                            input int rr_beat, input int abort_beat, input bit rnd, input bit fixed);
    bit own;
    own = pick(i_arvalid, d_arvalid, last_own);
    tick();
    serve_burst(own, ar_stall, rv_pct, rr_pct, rr_beat, abort_beat, rnd, fixed);
  endtask

  initial begin
    int unsigned k;
    do_reset();

    // Single icache burst with fixed beat data 0x11..0x88
    i_araddr = 32'hBFC0_0000; i_arlen = 8'd7; i_arvalid = 1'b1;
    #1;
    chk("req_latency", arvalid, 0);
    next_burst(0, 0, 0, -1, -1, 1'b0, 1'b1);

    // Simultaneous requests, from a fresh reset so the tie-breaker starts from its reset state
    do_reset();
    for (int unsigned rep = 0; rep < 4; rep++) begin
      i_araddr = $urandom & 32'hFFFF_FFFC; i_arlen = 8'd3; i_arvalid = 1'b1;
      d_araddr = 32'h8000_1000; d_arlen = 8'd3; d_arvalid = 1'b1;
      next_burst(0, 0, 0, -1, -1, 1'b0, 1'b0);
      next_burst(0, 0, 0, -1, -1, 1'b0, 1'b0);
    end

    // Address backpressure for 5 cycles, then beat 3 held off by the icache
    raise(1'b0); i_arlen = 8'd7;
    next_burst(5, 0, 0, 2, -1, 1'b0, 1'b0);

    // Reset during beat 4 of 8, then a fresh single-beat request
    i_araddr = 32'h0000_2000; i_arlen = 8'd7; i_arvalid = 1'b1;
    next_burst(0, 0, 0, -1, 3, 1'b0, 1'b1);
    raise(1'b1); d_arlen = 8'd0;
    next_burst(0, 0, 0, -1, -1, 1'b0, 1'b0);

    // Randomized traffic with stalls on both channels and requests arriving mid-burst
    for (int unsigned n = 0; n < 60; n++) begin
      if (!i_arvalid && !d_arvalid) begin
        k = $urandom_range(1, 3);
        if (k[0]) raise(1'b0);
        if (k[1]) raise(1'b1);
      end
      next_burst(int'($urandom_range(3)), 20, 20, -1, -1, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
